swizzle_delay_unit: RTL

SWIZZLE_DELAY_UNIT -- requirements
Module: swizzle_delay_unit

---
 rtl/swizzle_delay_pkg.sv | 19 +
 rtl/swizzle_delay_unit_if.sv | 30 +++
 rtl/delay_lane.sv | 97 +++++++++
 rtl/swizzle_delay_unit.sv | 50 +++++
 4 files changed

// File: rtl/swizzle_delay_pkg.sv
// Shared constants and helpers for the swizzle delay unit.
//   DefWidth / DefChannels / DefDepth : default payload width, channel count, lane depth
//   count_width() : bits needed to hold an occupancy of 0..depth
//   route()       : output channel fed by a given input channel
package swizzle_delay_pkg;

  localparam int unsigned DefWidth    = 5;
  localparam int unsigned DefChannels = 2;
  localparam int unsigned DefDepth    = 3;

  function automatic int unsigned count_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned route(int unsigned idx, int unsigned channels, bit reverse);
    return reverse ? (channels - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/swizzle_delay_unit_if.sv
// Ready/valid bus bundle for the swizzle delay unit.
//   I_data/I_valid/I_ready : per-channel input side, channel i at [i*WIDTH +: WIDTH]
//   O_data/O_valid/O_ready : per-channel output side, same packing
//   slave  : the delay unit's view
//   master : the producer/consumer view
interface swizzle_delay_unit_if
  import swizzle_delay_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned CHANNELS = DefChannels
);

  logic [CHANNELS*WIDTH-1:0] I_data;
  logic [CHANNELS-1:0]       I_valid;
  logic [CHANNELS-1:0]       I_ready;
  logic [CHANNELS*WIDTH-1:0] O_data;
  logic [CHANNELS-1:0]       O_valid;
  logic [CHANNELS-1:0]       O_ready;

  modport slave (
    input  I_data, I_valid, O_ready,
    output I_ready, O_data, O_valid
  );

  modport master (
    output I_data, I_valid, O_ready,
    input  I_ready, O_data, O_valid
  );

endinterface

// File: rtl/delay_lane.sv
// Single-channel elastic pipeline of DEPTH stages with bubble collapse.
//   clk_i, rst_i (sync, active high), flush_i (sync discard)
//   in_data_i/in_valid_i/in_ready_o    : upstream handshake
//   out_data_o/out_valid_o/out_ready_i : downstream handshake, driven from the last stage
//   count_o : number of occupied stages
//   busy_o  : any stage occupied
module delay_lane
  import swizzle_delay_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [WIDTH-1:0]              in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [WIDTH-1:0]              out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [count_width(DEPTH)-1:0] count_o,
  output logic                          busy_o
);

  localparam int unsigned CW = count_width(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d, adv;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             accept, drain;

  // adv[k]: stage k hands its beat downstream this cycle. A stage may move when the
  // stage after it is empty or is itself moving, so the chain resolves from the output back.
  always_comb begin
    logic down_free;
    adv       = '0;
    down_free = out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k]    = valid_q[k] & down_free;
      down_free = ~valid_q[k] | adv[k];
    end
  end

  assign in_ready_o  = (~valid_q[0] | adv[0]) & ~flush_i & ~rst_i;
  assign accept      = in_valid_i & in_ready_o;
  assign drain       = adv[DEPTH-1] & ~rst_i;
  // Masked during reset so a beat discarded by reset is never seen as delivered.
  assign out_valid_o = valid_q[DEPTH-1] & ~rst_i;
  assign out_data_o  = data_q[DEPTH-1];
  assign count_o     = count_q;
  assign busy_o      = |valid_q;

  always_comb begin
    logic             take;
    logic [WIDTH-1:0] src;
    take = accept;
    src  = in_data_i;
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = (valid_q[k] & ~adv[k]) | take;
      data_d[k]  = take ? src : data_q[k];
      take       = adv[k];
      src        = data_q[k];
    end
    if (flush_i) valid_d = '0;
  end

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (accept && !drain) begin
      count_d = count_q + CW'(1);
    end else if (drain && !accept) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Payload registers carry no reset: the valid bits alone decide what is live.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < DEPTH; k++) begin
      data_q[k] <= data_d[k];
    end
  end

endmodule

// File: rtl/swizzle_delay_unit.sv
// Multi-channel delay unit: one independent delay_lane per channel, with input channel i
// routed to output channel CHANNELS-1-i (REVERSE=1) or i (REVERSE=0).
//   CLK, RESET (sync, active high), FLUSH (sync discard of in-flight beats)
//   bus     : ready/valid bundle (slave side)
//   O_count : per-output-channel occupancy, count_width(DEPTH) bits each
//   BUSY    : any stage of any lane occupied
module swizzle_delay_unit
  import swizzle_delay_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned REVERSE  = 1
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   FLUSH,
  swizzle_delay_unit_if.slave                    bus,
  output logic [CHANNELS*count_width(DEPTH)-1:0] O_count,
  output logic                                   BUSY
);

  localparam int unsigned CW = count_width(DEPTH);

  logic [CHANNELS-1:0] lane_busy;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    localparam int unsigned OutIdx = route(i, CHANNELS, REVERSE != 0);

    delay_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk_i       (CLK),
      .rst_i       (RESET),
      .flush_i     (FLUSH),
      .in_data_i   (bus.I_data[i*WIDTH +: WIDTH]),
      .in_valid_i  (bus.I_valid[i]),
      .in_ready_o  (bus.I_ready[i]),
      .out_data_o  (bus.O_data[OutIdx*WIDTH +: WIDTH]),
      .out_valid_o (bus.O_valid[OutIdx]),
      .out_ready_i (bus.O_ready[OutIdx]),
      .count_o     (O_count[OutIdx*CW +: CW]),
      .busy_o      (lane_busy[i])
    );
  end

  assign BUSY = |lane_busy;

endmodule
